// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - segment/select constants and capture FSM state type for the seven-segment bus monitor
package seven_seg_pkg;

    // Active-low bus patterns {~dp,~a,~b,~c,~d,~e,~f,~g}, decimal point dark.
    localparam logic [7:0] SEG_0     = 8'h81;
    localparam logic [7:0] SEG_1     = 8'hCF;
    localparam logic [7:0] SEG_2     = 8'h92;
    localparam logic [7:0] SEG_3     = 8'h86;
    localparam logic [7:0] SEG_4     = 8'hCC;
    localparam logic [7:0] SEG_5     = 8'hA4;
    localparam logic [7:0] SEG_6     = 8'hA0;
    localparam logic [7:0] SEG_7     = 8'h8F;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h84;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] SEL_NONE  = 4'hF;
    localparam logic [3:0] SEL_A     = 4'hE;
    localparam logic [3:0] SEL_B     = 4'hD;
    localparam logic [3:0] SEL_C     = 4'hB;
    localparam logic [3:0] SEL_D     = 4'h7;

    typedef enum logic {SEEK, COLLECT} capture_state_t;

    function automatic logic [1:0] sel_index(input logic [3:0] sel);
        logic [1:0] idx;
        idx = 2'd0;
        case (sel)
            SEL_B:   idx = 2'd1;
            SEL_C:   idx = 2'd2;
            SEL_D:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seven_seg_pattern_decoder.sv
// rtl/seven_seg_pattern_decoder.sv - active-low abcdefg pattern to BCD value, hit=0 for non-digit patterns
module seven_seg_pattern_decoder
    import seven_seg_pkg::*;
(
    input  logic [6:0] segments,
    output logic       hit,
    output logic [3:0] value
);

    always_comb begin
        hit   = 1'b1;
        value = 4'd0;
        case (segments)
            SEG_0[6:0]: value = 4'd0;
            SEG_1[6:0]: value = 4'd1;
            SEG_2[6:0]: value = 4'd2;
            SEG_3[6:0]: value = 4'd3;
            SEG_4[6:0]: value = 4'd4;
            SEG_5[6:0]: value = 4'd5;
            SEG_6[6:0]: value = 4'd6;
            SEG_7[6:0]: value = 4'd7;
            SEG_8[6:0]: value = 4'd8;
            SEG_9[6:0]: value = 4'd9;
            default:    hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - multiplexed 4-digit seven-segment bus receiver rebuilding digits and decimal points
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] select,
    input  logic [7:0] segments,
    output logic [3:0] digit_a,
    output logic [3:0] digit_b,
    output logic [3:0] digit_c,
    output logic [3:0] digit_d,
    output logic [3:0] dp,
    output logic [3:0] digit_valid,
    output logic       frame_done,
    output logic       err
);

    localparam int             CW         = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  STABLE_MAX = CW'(STABLE_CYCLES);

    logic [11:0]    sync1, sync2, prev;
    logic [CW-1:0]  run_cnt, run_cnt_n;
    logic           changed, cap_fire;
    logic           cap_valid;
    logic [11:0]    cap_sample;

    logic [3:0]     cap_sel;
    logic [7:0]     cap_seg;
    logic           one_hot_sel, is_write, is_err;
    logic [1:0]     idx;
    logic           dec_hit;
    logic [3:0]     dec_value;

    capture_state_t state, state_n;
    logic [1:0]     expect_idx, expect_idx_n;
    logic           err_n, done_n;

    always_comb begin
        changed   = (sync2 != prev);
        run_cnt_n = changed ? CW'(1)
                  : (run_cnt == STABLE_MAX) ? run_cnt : run_cnt + CW'(1);
        // Only the cycle the run first reaches the threshold counts; a saturated run stays silent.
        cap_fire  = (run_cnt_n == STABLE_MAX) && (changed || (run_cnt != STABLE_MAX));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '1;
            sync2      <= '1;
            prev       <= '1;
            run_cnt    <= '0;
            cap_valid  <= 1'b0;
            cap_sample <= '1;
        end else begin
            sync1      <= {select, segments};
            sync2      <= sync1;
            prev       <= sync2;
            run_cnt    <= run_cnt_n;
            cap_valid  <= cap_fire;
            cap_sample <= sync2;
        end
    end

    assign cap_sel = cap_sample[11:8];
    assign cap_seg = cap_sample[7:0];

    seven_seg_pattern_decoder u_decoder (
        .segments (cap_seg[6:0]),
        .hit      (dec_hit),
        .value    (dec_value)
    );

    always_comb begin
        one_hot_sel = (cap_sel == SEL_A) || (cap_sel == SEL_B) ||
                      (cap_sel == SEL_C) || (cap_sel == SEL_D);
        idx         = sel_index(cap_sel);
        is_write    = 1'b0;
        is_err      = 1'b0;
        if (cap_valid && (cap_sel != SEL_NONE)) begin
            if (!one_hot_sel)
                is_err = 1'b1;
            else if (cap_seg != SEG_BLANK) begin
                if (dec_hit)
                    is_write = 1'b1;
                else
                    is_err = 1'b1;
            end
        end
    end

    always_comb begin
        state_n      = state;
        expect_idx_n = expect_idx;
        err_n        = 1'b0;
        done_n       = 1'b0;
        if (is_err) begin
            err_n   = 1'b1;
            state_n = SEEK;
        end else if (is_write) begin
            case (state)
                SEEK: begin
                    if (idx == 2'd0) begin
                        state_n      = COLLECT;
                        expect_idx_n = 2'd1;
                    end
                end
                COLLECT: begin
                    if (idx == expect_idx) begin
                        if (idx == 2'd3) begin
                            done_n  = 1'b1;
                            state_n = SEEK;
                        end else begin
                            expect_idx_n = expect_idx + 2'd1;
                        end
                    end else begin
                        err_n = 1'b1;
                        // An early digit a is taken as the start of a fresh frame.
                        if (idx == 2'd0) begin
                            state_n      = COLLECT;
                            expect_idx_n = 2'd1;
                        end else begin
                            state_n = SEEK;
                        end
                    end
                end
                default: state_n = SEEK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SEEK;
            expect_idx  <= 2'd0;
            err         <= 1'b0;
            frame_done  <= 1'b0;
            digit_a     <= 4'd0;
            digit_b     <= 4'd0;
            digit_c     <= 4'd0;
            digit_d     <= 4'd0;
            dp          <= 4'd0;
            digit_valid <= 4'd0;
        end else begin
            state      <= state_n;
            expect_idx <= expect_idx_n;
            err        <= err_n;
            frame_done <= done_n;
            if (is_write) begin
                case (idx)
                    2'd0:    digit_a <= dec_value;
                    2'd1:    digit_b <= dec_value;
                    2'd2:    digit_c <= dec_value;
                    default: digit_d <= dec_value;
                endcase
                dp[idx]          <= ~cap_seg[7];
                digit_valid[idx] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - directed self-checking bench for seven_seg_capture
module tb_seven_seg_capture;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] select;
    logic [7:0] segments;
    logic [3:0] digit_a, digit_b, digit_c, digit_d;
    logic [3:0] dp, digit_valid;
    logic       frame_done, err;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int both_cnt    = 0;
    int err_base, done_base;

    seven_seg_capture #(.STABLE_CYCLES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .select      (select),
        .segments    (segments),
        .digit_a     (digit_a),
        .digit_b     (digit_b),
        .digit_c     (digit_c),
        .digit_d     (digit_d),
        .dp          (dp),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)        done_cnt++;
        if (err)               err_cnt++;
        if (frame_done && err) both_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] s, input logic [7:0] g, input int n);
        select   = s;
        segments = g;
        tick(n);
    endtask

    task automatic show(input logic [3:0] s, input logic [7:0] g);
        drive(s, 8'hFF, 4);
        drive(s, g, 4);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        select   = 4'hF;
        segments = 8'hFF;
        tick(3);
        chk("reset_digits", {digit_a, digit_b, digit_c, digit_d}, 16'h0000);
        chk("reset_flags", {4'h0, dp, digit_valid, 2'b00, frame_done, err}, 16'h0000);
        reset_n = 1'b1;
        tick(6);

        // single digit a=1, latency 5
        drive(4'hE, 8'hCF, 4);
        chk("lat_before", {8'h00, digit_valid, digit_a}, 16'h0000);
        tick(1);
        chk("lat_digit_a", {12'h000, digit_a}, 16'h0001);
        chk("lat_valid_dp", {8'h00, digit_valid, dp}, 16'h0010);
        tick(1);
        chk("single_no_err", 16'(err_cnt), 16'd0);

        // reset mid-frame clears outputs immediately
        reset_n = 1'b0;
        #1;
        chk("midreset_out", {digit_a, digit_valid, dp, 2'b00, frame_done, err}, 16'h0000);
        select   = 4'hF;
        segments = 8'hFF;
        tick(2);
        reset_n = 1'b1;
        tick(6);

        // full ring 4,2,9,0
        err_base  = err_cnt;
        done_base = done_cnt;
        show(4'hE, 8'hCC);
        show(4'hD, 8'h92);
        show(4'hB, 8'h84);
        show(4'h7, 8'h81);
        tick(6);
        chk("ring1_digits", {digit_a, digit_b, digit_c, digit_d}, 16'h4290);
        chk("ring1_done", 16'(done_cnt - done_base), 16'd1);
        chk("ring1_err", 16'(err_cnt - err_base), 16'd0);
        chk("ring1_valid_dp", {8'h00, digit_valid, dp}, 16'h00F0);

        // repeated ring, d with decimal point lit
        show(4'hE, 8'hCC);
        show(4'hD, 8'h92);
        show(4'hB, 8'h84);
        show(4'h7, 8'h01);
        tick(6);
        chk("ring2_done", 16'(done_cnt - done_base), 16'd2);
        chk("ring2_err", 16'(err_cnt - err_base), 16'd0);
        chk("ring2_dp", {12'h000, dp}, 16'h0008);
        chk("ring2_digit_d", {12'h000, digit_d}, 16'h0000);

        // one-cycle glitch is not captured
        drive(4'hE, 8'hFF, 4);
        drive(4'hE, 8'hCF, 1);
        drive(4'hE, 8'hFF, 6);
        chk("glitch_digit_a", {12'h000, digit_a}, 16'h0004);
        chk("glitch_err", 16'(err_cnt - err_base), 16'd0);

        // bad pattern, multi-hot select, idle select, blank
        drive(4'hE, 8'hBF, 6);
        chk("badpat_err", 16'(err_cnt - err_base), 16'd1);
        chk("badpat_digit_a", {12'h000, digit_a}, 16'h0004);
        drive(4'hE, 8'hFF, 4);
        drive(4'hC, 8'hCF, 6);
        chk("multihot_err", 16'(err_cnt - err_base), 16'd2);
        drive(4'hF, 8'hCF, 6);
        drive(4'hD, 8'hFF, 6);
        chk("idle_blank_err", 16'(err_cnt - err_base), 16'd2);
        chk("idle_blank_digits", {digit_a, digit_b, digit_c, digit_d}, 16'h4290);

        // 8'hA4 decodes to 5 on digit b; lone b in SEEK is silent
        drive(4'hD, 8'hA4, 6);
        chk("b_is_5", {12'h000, digit_b}, 16'h0005);
        chk("b_seek_err", 16'(err_cnt - err_base), 16'd2);

        // out of order a then c
        err_base  = err_cnt;
        done_base = done_cnt;
        show(4'hE, 8'hCC);
        show(4'hB, 8'h86);
        tick(4);
        chk("order_err", 16'(err_cnt - err_base), 16'd1);
        chk("order_done", 16'(done_cnt - done_base), 16'd0);
        chk("order_digit_c", {12'h000, digit_c}, 16'h0003);
        show(4'hE, 8'hCC);
        show(4'hD, 8'h92);
        show(4'hB, 8'h84);
        show(4'h7, 8'h81);
        tick(6);
        chk("recover_done", 16'(done_cnt - done_base), 16'd1);
        chk("recover_err", 16'(err_cnt - err_base), 16'd1);
        chk("recover_digits", {digit_a, digit_b, digit_c, digit_d}, 16'h4290);
        chk("recover_dp", {12'h000, dp}, 16'h0000);
        chk("err_done_overlap", 16'(both_cnt), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
